mult4_mac_stage: RTL and testbench
==================================

// Module: mult4_mac_stage
// PURPOSE
//  Sequential multiply-accumulate stage wrapped around the 4x4 unsigned array multiplier (module main: x[3:0], y[3:0] -> o[7:0]).
//  Accepts a stream of operand pairs over valid/ready and registers each pair into the multiplier inputs.
//  Sums the 8-bit products over a frame delimited by in_last, then presents the frame sum, beat count and overflow flag downstream over valid/ready.
// PARAMETERS
//  ACC_W  16  accumulator/result width in bits; legal range 8..32
//  CNT_W  8   beat-counter width in bits; legal range 1..16
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      stage can accept an operand pair
//  in_x       in   4      multiplicand, unsigned
//  in_y       in   4      multiplier, unsigned
//  in_last    in   1      final beat of frame; qualified by in_valid
//  out_valid  out  1      frame result valid
//  out_ready  in   1      downstream accepts result
//  out_acc    out  ACC_W  frame sum of in_x*in_y, saturating
//  out_count  out  CNT_W  beats in frame, saturating at 2^CNT_W-1
//  out_ovf    out  1      sticky: accumulator saturated during this frame
// BEHAVIOUR
//  Reset (asynchronous, while rst_n=0):
//   - state=ACCUM; s1_valid=0; acc=0; count=0; ovf=0; out_valid=0.
//   - out_acc, out_count and out_ovf read 0; in_ready=1 from the first edge after deassertion.
//  Stage 1 register: on in_valid&&in_ready, capture x, y and last into s1_x, s1_y, s1_last, and set s1_valid=1.
//   - Otherwise s1_valid=0.
//   - s1_x and s1_y drive the multiplier instance directly.
//  Stage 2 (accumulate): each cycle s1_valid=1:
//   - acc <= sat(acc + zero_ext(o)), where sat clamps to 2^ACC_W-1.
//   - A clamp sets ovf=1 until the frame is consumed.
//   - count <= count+1, saturating at all-ones.
//  FSM (2-bit):
//   ACCUM: in_ready=1.
//    - Accepting a beat with in_last=1 -> FLUSH.
//   FLUSH: in_ready=0; s1 holds the last beat.
//    - On that cycle's accumulate -> OUTPUT, with out_valid<=1 on the same edge.
//   OUTPUT: in_ready=0; out_valid=1; out_acc, out_count and out_ovf are held stable.
//    - On out_ready=1: out_valid<=0; acc, count and ovf <= 0; state -> ACCUM.
//  Latency:
//   - Last beat accepted at edge E -> accumulated at edge E+1 -> out_valid=1 in the cycle after E+1.
//   - Throughput: 1 beat/cycle within a frame.
//   - Frame overhead: 1 FLUSH cycle + >=1 OUTPUT cycle.
//  out_acc, out_count and out_ovf are driven directly from acc, count and ovf.
//   - They change only in ACCUM/FLUSH.
//   - Downstream samples them only when out_valid=1.
//  Boundary conditions:
//   - Back-to-back beats: s1 is overwritten each cycle; no bubble is required.
//   - Single-beat frame (in_last on the first beat) is legal: out_count=1.
//   - A zero-beat frame does not exist: a frame always has >=1 beat.
//   - out_ready=1 while out_valid=0 is ignored.
//   - in_valid while in_ready=0 is ignored; upstream must hold its data.
//   - Count saturation does not set ovf; only accumulator clamping does.
//   - rst_n asserted mid-frame or in OUTPUT discards all partial state immediately and asynchronously.
// TESTING
//  1. Reset: hold rst_n=0 for 3 clk -> out_valid=0, out_acc=0, out_count=0, out_ovf=0; first cycle after release in_ready=1.
//  2. Single beat x=15, y=15, last=1, out_ready=1 -> out_valid high exactly 2 cycles after acceptance, out_acc=225, out_count=1, out_ovf=0.
//  3. Back-to-back frame (3,5), (7,2), (15,15,last) -> out_acc=254, out_count=3; in_ready=0 from FLUSH until the result is consumed.
//  4. Backpressure: out_ready=0 for 5 cycles in OUTPUT -> outputs stable, in_ready=0; then release -> next frame (2,3,last) gives out_acc=6 (no carry-over).
//  5. Saturation, ACC_W=10: five beats of 15x15 (sum 1125) -> out_acc=1023, out_ovf=1; next frame (1,1,last) -> out_acc=1, out_ovf=0.
//  6. Reset mid-frame after 2 beats, then (2,3,last) -> out_acc=6, out_count=1. Also run exhaustive single-beat frames over all 256 (x,y) pairs -> out_acc==x*y.

Source files
------------

// File: rtl/mult4_mac_stage.sv
// Multiply-accumulate stage: registers operand pairs into a 4x4 array multiplier,
// sums products over an in_last-delimited frame and hands the result downstream.

module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  // Partial-product rows, each gated by one multiplier bit and shifted into place.
  always_comb begin
    o = 8'd0;
    for (int i = 0; i < 4; i++) begin
      o = o + ({4'b0000, x & {4{y[i]}}} << i);
    end
  end

endmodule

module mult4_mac_stage #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         s1_x_q, s1_y_q;
  logic               s1_last_q, s1_valid_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               accept_s;
  logic               consume_s;
  logic [7:0]         prod_s;
  logic [ACC_W:0]     sum_s;

  assign accept_s  = in_valid & in_ready;
  assign consume_s = (state_q == ST_OUTPUT) & out_ready;

  main u_mult (
    .x (s1_x_q),
    .y (s1_y_q),
    .o (prod_s)
  );

  // The carry bit of the widened sum tells us the accumulator would wrap.
  assign sum_s = {1'b0, acc_q} + {1'b0, ACC_W'(prod_s)};

  // Stage 1 operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x_q     <= 4'd0;
      s1_y_q     <= 4'd0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else if (accept_s) begin
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_last_q  <= in_last;
      s1_valid_q <= 1'b1;
    end else begin
      s1_valid_q <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s && in_last) state_d = ST_FLUSH;
        else                     state_d = ST_ACCUM;
      end
      ST_FLUSH: begin
        if (s1_valid_q && s1_last_q) state_d = ST_OUTPUT;
        else                         state_d = ST_FLUSH;
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_ACCUM;
        else           state_d = ST_OUTPUT;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_ACCUM:  in_ready = 1'b1;
      ST_FLUSH:  in_ready = 1'b0;
      ST_OUTPUT: in_ready = 1'b0;
      default:   in_ready = 1'b0;
    endcase
  end

  // Accumulator, beat counter and sticky overflow; cleared when the result is taken.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (consume_s) begin
      acc_d   = {ACC_W{1'b0}};
      count_d = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
    end else if (s1_valid_q) begin
      if (sum_s[ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
        ovf_d = ovf_q;
      end
      if (&count_q) count_d = count_q;
      else          count_d = count_q + CNT_W'(1);
    end else begin
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // Result valid rises with the final accumulate and falls on handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    if ((state_q == ST_FLUSH) && s1_valid_q && s1_last_q) begin
      out_valid_d = 1'b1;
    end else if (consume_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= {ACC_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult4_mac_stage.sv
// Directed bench: one 16-bit and one 10-bit accumulator instance driven by the
// same stimulus, so the saturating instance can be checked alongside the wide one.

module tb_mult4_mac_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_x;
  logic [3:0]  in_y;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_acc_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [9:0]  out_acc_b;
  logic [7:0]  out_count_b;

  int checks = 0;
  int errors = 0;
  int bx[8];
  int by[8];

  always #5 clk = ~clk;

  mult4_mac_stage #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_acc   (out_acc_a),
    .out_count (out_count_a),
    .out_ovf   (out_ovf_a)
  );

  mult4_mac_stage #(.ACC_W(10), .CNT_W(8)) dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_acc   (out_acc_b),
    .out_count (out_count_b),
    .out_ovf   (out_ovf_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input int e16, input int e10, input int ecnt,
                              input logic eo16, input logic eo10);
    check_val({tag, " valid16"}, {31'd0, out_valid_a}, 32'd1);
    check_val({tag, " valid10"}, {31'd0, out_valid_b}, 32'd1);
    check_val({tag, " ready16"}, {31'd0, in_ready_a}, 32'd0);
    check_val({tag, " ready10"}, {31'd0, in_ready_b}, 32'd0);
    check_val({tag, " acc16"}, {16'd0, out_acc_a}, e16);
    check_val({tag, " acc10"}, {22'd0, out_acc_b}, e10);
    check_val({tag, " cnt16"}, {24'd0, out_count_a}, ecnt);
    check_val({tag, " cnt10"}, {24'd0, out_count_b}, ecnt);
    check_val({tag, " ovf16"}, {31'd0, out_ovf_a}, {31'd0, eo16});
    check_val({tag, " ovf10"}, {31'd0, out_ovf_b}, {31'd0, eo10});
  endtask

  // Sends bx/by[0..n-1] back to back, then checks FLUSH, OUTPUT and the handshake.
  task automatic run_frame(input string tag, input int n, input int e16, input int e10,
                           input int ecnt, input logic eo16, input logic eo10,
                           input int hold, input logic rdy_early);
    out_ready = rdy_early;
    for (int i = 0; i < n; i++) begin
      in_x     = 4'(bx[i]);
      in_y     = 4'(by[i]);
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      check_val({tag, " beat_ready"}, {31'd0, in_ready_a & in_ready_b}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    // FLUSH cycle: result not yet valid, input stalled.
    check_val({tag, " flush_valid"}, {31'd0, out_valid_a | out_valid_b}, 32'd0);
    check_val({tag, " flush_ready"}, {31'd0, in_ready_a | in_ready_b}, 32'd0);
    @(negedge clk);
    check_result(tag, e16, e10, ecnt, eo16, eo10);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x     = 4'd9;
      in_y     = 4'd9;
      @(negedge clk);
      check_result({tag, " hold"}, e16, e10, ecnt, eo16, eo10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, " done_valid"}, {31'd0, out_valid_a | out_valid_b}, 32'd0);
    check_val({tag, " done_ready"}, {31'd0, in_ready_a & in_ready_b}, 32'd1);
    check_val({tag, " done_acc16"}, {16'd0, out_acc_a}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 4'd0;
    in_y      = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst valid", {31'd0, out_valid_a | out_valid_b}, 32'd0);
    check_val("rst acc16", {16'd0, out_acc_a}, 32'd0);
    check_val("rst acc10", {22'd0, out_acc_b}, 32'd0);
    check_val("rst cnt", {24'd0, out_count_a | out_count_b}, 32'd0);
    check_val("rst ovf", {31'd0, out_ovf_a | out_ovf_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst in_ready", {31'd0, in_ready_a & in_ready_b}, 32'd1);

    bx[0] = 15; by[0] = 15;
    run_frame("single", 1, 225, 225, 1, 1'b0, 1'b0, 0, 1'b1);

    bx[0] = 3; by[0] = 5; bx[1] = 7; by[1] = 2; bx[2] = 15; by[2] = 15;
    run_frame("b2b", 3, 254, 254, 3, 1'b0, 1'b0, 0, 1'b0);

    bx[0] = 4; by[0] = 4; bx[1] = 1; by[1] = 9;
    run_frame("bp", 2, 25, 25, 2, 1'b0, 1'b0, 5, 1'b0);
    bx[0] = 2; by[0] = 3;
    run_frame("after_bp", 1, 6, 6, 1, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bx[i] = 15; by[i] = 15;
    end
    run_frame("sat", 5, 1125, 1023, 5, 1'b0, 1'b1, 0, 1'b0);
    bx[0] = 1; by[0] = 1;
    run_frame("after_sat", 1, 1, 1, 1, 1'b0, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 2; i++) begin
      in_x = 4'd6; in_y = 4'd7; in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst acc16", {16'd0, out_acc_a}, 32'd0);
    check_val("midrst cnt16", {24'd0, out_count_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bx[0] = 2; by[0] = 3;
    run_frame("midrst_next", 1, 6, 6, 1, 1'b0, 1'b0, 0, 1'b0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        bx[0] = x; by[0] = y;
        run_frame("exh", 1, x * y, x * y, 1, 1'b0, 1'b0, 0, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
